// File: rtl/video_packer.sv
// Packs 1-bit-per-colour pixels into bytes for three video RAM planes and
// sequences the blue/red/green byte writes through a request/ack handshake.
module video_packer #(
   parameter int ABITS = 13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ce,
   input  logic             de,
   input  logic             sof,
   input  logic [2:0]       pixel,
   output logic             we,
   input  logic             ack,
   output logic [ABITS-1:0] a,
   output logic [1:0]       b,
   output logic [7:0]       d,
   output logic             ovf
);

   typedef enum logic [1:0] {IDLE, BLUE, RED, GREEN} state_t;

   state_t           state;
   logic [2:0]       pix_cnt;
   logic [ABITS-1:0] addr_cnt;
   logic [7:0]       sr_r, sr_g, sr_b;
   logic [7:0]       hold_r, hold_g, hold_b;
   logic [ABITS-1:0] hold_addr;
   logic             hold_vld;
   logic [7:0]       work_r, work_g;

   logic       grp;
   logic       ready;
   logic [7:0] new_r, new_g, new_b;

   // A group completes on the 8th pixel; sof restarts the count so it never completes one.
   assign grp   = ce && de && !sof && (pix_cnt == 3'd7);
   assign new_r = {sr_r[6:0], pixel[2]};
   assign new_g = {sr_g[6:0], pixel[1]};
   assign new_b = {sr_b[6:0], pixel[0]};
   assign ready = (state == IDLE) || (state == GREEN && ack);

   // Pixel shift/count path
   always_ff @(posedge clock) begin
      if (reset) begin
         pix_cnt  <= '0;
         addr_cnt <= '0;
         sr_r     <= '0;
         sr_g     <= '0;
         sr_b     <= '0;
      end else if (ce) begin
         if (sof) begin
            addr_cnt <= '0;
            pix_cnt  <= de ? 3'd1 : 3'd0;
            sr_r     <= {7'd0, de & pixel[2]};
            sr_g     <= {7'd0, de & pixel[1]};
            sr_b     <= {7'd0, de & pixel[0]};
         end else if (de) begin
            sr_r    <= new_r;
            sr_g    <= new_g;
            sr_b    <= new_b;
            pix_cnt <= pix_cnt + 3'd1;
            if (pix_cnt == 3'd7)
               addr_cnt <= addr_cnt + ABITS'(1);
         end
      end
   end

   // Holding registers and write sequencer
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         we        <= 1'b0;
         a         <= '0;
         b         <= 2'd0;
         d         <= 8'd0;
         ovf       <= 1'b0;
         hold_r    <= '0;
         hold_g    <= '0;
         hold_b    <= '0;
         hold_addr <= '0;
         hold_vld  <= 1'b0;
         work_r    <= '0;
         work_g    <= '0;
      end else if (ready) begin
         if (hold_vld) begin
            state  <= BLUE;
            we     <= 1'b1;
            b      <= 2'd0;
            d      <= hold_b;
            a      <= hold_addr;
            work_r <= hold_r;
            work_g <= hold_g;
            if (grp) begin
               hold_r    <= new_r;
               hold_g    <= new_g;
               hold_b    <= new_b;
               hold_addr <= addr_cnt;
            end else begin
               hold_vld <= 1'b0;
            end
         end else if (grp) begin
            // Bypass the holding stage so an idle sequencer writes on the next cycle.
            state  <= BLUE;
            we     <= 1'b1;
            b      <= 2'd0;
            d      <= new_b;
            a      <= addr_cnt;
            work_r <= new_r;
            work_g <= new_g;
         end else begin
            state <= IDLE;
            we    <= 1'b0;
         end
      end else begin
         if (grp) begin
            if (hold_vld) begin
               ovf <= 1'b1;
            end else begin
               hold_r    <= new_r;
               hold_g    <= new_g;
               hold_b    <= new_b;
               hold_addr <= addr_cnt;
               hold_vld  <= 1'b1;
            end
         end
         case (state)
            BLUE: if (ack) begin
               state <= RED;
               b     <= 2'd1;
               d     <= work_r;
            end
            RED: if (ack) begin
               state <= GREEN;
               b     <= 2'd2;
               d     <= work_g;
            end
            default: ;
         endcase
      end
   end

endmodule
